// File: rtl/ycrcb_stream_pkg.sv
// Shared field layout and pairing-state encoding for the YCrCb streaming blocks.
package ycrcb_stream_pkg;

  localparam int Y_MSB  = 31;
  localparam int Y_LSB  = 24;
  localparam int CR_MSB = 23;
  localparam int CR_LSB = 16;
  localparam int CB_MSB = 15;
  localparam int CB_LSB = 8;

  localparam int OUT_Y_MSB = 15;
  localparam int OUT_Y_LSB = 8;
  localparam int OUT_C_MSB = 7;
  localparam int OUT_C_LSB = 0;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_SOLO = 2'd2
  } pair_state_e;

endpackage

// File: rtl/chroma_avg.sv
// Average of two 8-bit chroma samples; 9-bit sum so 0xFF+0xFF cannot overflow.
module chroma_avg #(
  parameter bit ROUND = 1'b1
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] avg
);

  logic [8:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + 9'(ROUND);
  assign avg = 8'(sum >> 1);

endmodule

// File: rtl/ycrcb444_to_422_subsampler.sv
// Converts 4:4:4 {Y,Cr,Cb,pad} pixels into 4:2:2 {Y,C} words, averaging chroma per pixel pair.
module ycrcb444_to_422_subsampler
  import ycrcb_stream_pkg::*;
#(
  parameter int DATAIN_WIDTH  = 32,
  parameter int DATAOUT_WIDTH = 16,
  parameter bit CHROMA_ROUND  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATAIN_WIDTH-1:0]  datain,
  input  logic                     datain_valid,
  input  logic                     datain_last,
  output logic                     datain_ready,
  output logic [DATAOUT_WIDTH-1:0] dataout,
  output logic                     dataout_valid,
  output logic                     dataout_last,
  input  logic                     dataout_ready
);

  pair_state_e state;

  logic [7:0] ya, cra, cba;
  logic       a_last;

  logic [DATAOUT_WIDTH-1:0] hold_word;
  logic                     hold_valid;
  logic                     hold_last;

  logic [7:0] y_in, cr_in, cb_in;
  logic [7:0] cb_avg, cr_avg;
  logic       unused_pad;

  logic out_free, in_xfer, load_b, load_solo, drain;

  assign y_in       = datain[Y_MSB:Y_LSB];
  assign cr_in      = datain[CR_MSB:CR_LSB];
  assign cb_in      = datain[CB_MSB:CB_LSB];
  assign unused_pad = ^datain[CB_LSB-1:0];

  chroma_avg #(.ROUND(CHROMA_ROUND)) u_cb_avg (
    .a   (cba),
    .b   (cb_in),
    .avg (cb_avg)
  );

  chroma_avg #(.ROUND(CHROMA_ROUND)) u_cr_avg (
    .a   (cra),
    .b   (cr_in),
    .avg (cr_avg)
  );

  assign out_free = !dataout_valid || dataout_ready;

  // B is only taken when both its words have somewhere to go this cycle.
  always_comb begin
    datain_ready = 1'b0;
    if (!rst) begin
      case (state)
        S_A:     datain_ready = 1'b1;
        S_B:     datain_ready = !hold_valid && out_free;
        default: datain_ready = 1'b0;
      endcase
    end
  end

  assign in_xfer   = datain_valid && datain_ready;
  assign load_b    = (state == S_B) && in_xfer;
  assign load_solo = (state == S_SOLO) && !hold_valid && out_free;
  assign drain     = hold_valid && out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_A;
      ya            <= '0;
      cra           <= '0;
      cba           <= '0;
      a_last        <= 1'b0;
      hold_word     <= '0;
      hold_valid    <= 1'b0;
      hold_last     <= 1'b0;
      dataout       <= '0;
      dataout_valid <= 1'b0;
      dataout_last  <= 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (in_xfer) begin
            ya     <= y_in;
            cra    <= cr_in;
            cba    <= cb_in;
            a_last <= datain_last;
            state  <= datain_last ? S_SOLO : S_B;
          end
        end
        S_B: begin
          if (load_b) begin
            hold_word  <= DATAOUT_WIDTH'({y_in, cr_avg});
            hold_valid <= 1'b1;
            hold_last  <= datain_last;
            state      <= S_A;
          end
        end
        S_SOLO: begin
          if (load_solo) state <= S_A;
        end
        default: state <= S_A;
      endcase

      // Loads need an empty hold, so they never collide with a drain.
      if (load_b) begin
        dataout       <= DATAOUT_WIDTH'({ya, cb_avg});
        dataout_valid <= 1'b1;
        dataout_last  <= 1'b0;
      end else if (load_solo) begin
        dataout       <= DATAOUT_WIDTH'({ya, cba});
        dataout_valid <= 1'b1;
        dataout_last  <= a_last;
      end else if (drain) begin
        dataout       <= hold_word;
        dataout_valid <= 1'b1;
        dataout_last  <= hold_last;
        hold_valid    <= 1'b0;
      end else if (out_free) begin
        dataout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ycrcb444_to_422_subsampler.sv
// Directed bench for the 4:4:4 to 4:2:2 subsampler; a truncating twin checks CHROMA_ROUND=0.
module tb_ycrcb444_to_422_subsampler;

  logic        clk;
  logic        rst;
  logic [31:0] datain;
  logic        datain_valid;
  logic        datain_last;
  logic        datain_ready;
  logic [15:0] dataout;
  logic        dataout_valid;
  logic        dataout_last;
  logic        dataout_ready;

  logic [15:0] dataout_t;
  logic        dataout_valid_t;
  logic        dataout_last_t;
  logic        unused_ready_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAcceptCyc = 0;
  int lastOutCyc = 0;
  int firstInCyc = 0;
  int stalls = 0;

  logic [16:0] outQ[$];
  logic [16:0] truncQ[$];
  logic [15:0] heldWord;

  ycrcb444_to_422_subsampler #(.CHROMA_ROUND(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .datain        (datain),
    .datain_valid  (datain_valid),
    .datain_last   (datain_last),
    .datain_ready  (datain_ready),
    .dataout       (dataout),
    .dataout_valid (dataout_valid),
    .dataout_last  (dataout_last),
    .dataout_ready (dataout_ready)
  );

  ycrcb444_to_422_subsampler #(.CHROMA_ROUND(1'b0)) dut_trunc (
    .clk           (clk),
    .rst           (rst),
    .datain        (datain),
    .datain_valid  (datain_valid),
    .datain_last   (datain_last),
    .datain_ready  (unused_ready_t),
    .dataout       (dataout_t),
    .dataout_valid (dataout_valid_t),
    .dataout_last  (dataout_last_t),
    .dataout_ready (dataout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so negedge sees what the next edge will transfer.
  always @(negedge clk) begin
    if (!rst && dataout_valid && dataout_ready) begin
      outQ.push_back({dataout_last, dataout});
      lastOutCyc = cyc;
    end
    if (!rst && dataout_valid_t && dataout_ready)
      truncQ.push_back({dataout_last_t, dataout_t});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic l);
    bit accepted;
    int n;
    accepted = 1'b0;
    n = 0;
    datain       = d;
    datain_last  = l;
    datain_valid = 1'b1;
    while (!accepted && n < 50) begin
      @(negedge clk);
      accepted = datain_ready;
      if (accepted) lastAcceptCyc = cyc;
      else stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) checkOutput("in_timeout", 32'd0, 32'd1);
    datain_valid = 1'b0;
    datain_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic popWord(input string tag, input bit trunc, input logic [16:0] exp);
    int n;
    n = 0;
    while (((trunc ? truncQ.size() : outQ.size()) == 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((trunc ? truncQ.size() : outQ.size()) == 0)
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    else if (trunc)
      checkOutput(tag, 32'(truncQ.pop_front()), 32'(exp));
    else
      checkOutput(tag, 32'(outQ.pop_front()), 32'(exp));
  endtask

  function automatic logic [7:0] avgRound(input logic [7:0] a, input logic [7:0] b);
    return 8'((9'(a) + 9'(b) + 9'd1) >> 1);
  endfunction

  initial begin
    logic [7:0] yv[16];
    logic [7:0] crv[16];
    logic [7:0] cbv[16];

    rst           = 1'b1;
    dataout_ready = 1'b0;
    datain        = '0;
    datain_valid  = 1'b0;
    datain_last   = 1'b0;

    // Reset state
    idle(2);
    @(negedge clk);
    checkOutput("rst_valid", 32'(dataout_valid), 32'd0);
    checkOutput("rst_data", 32'(dataout), 32'd0);
    checkOutput("rst_last", 32'(dataout_last), 32'd0);
    checkOutput("rst_ready", 32'(datain_ready), 32'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    dataout_ready = 1'b1;

    // Basic pair with latency check
    applyStimulus(32'h1080_4000, 1'b0);
    applyStimulus(32'h2082_4300, 1'b0);
    @(negedge clk);
    checkOutput("basic_even_valid", 32'(dataout_valid), 32'd1);
    checkOutput("basic_even", 32'(dataout), 32'h1042);
    @(negedge clk);
    checkOutput("basic_odd_valid", 32'(dataout_valid), 32'd1);
    checkOutput("basic_odd", 32'(dataout), 32'h2081);
    @(posedge clk);
    #1;
    idle(2);
    outQ.delete();
    truncQ.delete();

    // Rounding in both modes
    applyStimulus(32'h1100_FE00, 1'b0);
    applyStimulus(32'h2201_FF00, 1'b0);
    popWord("rnd_even_r1", 1'b0, 17'h011FF);
    popWord("rnd_even_r0", 1'b1, 17'h011FE);
    popWord("rnd_odd_r1", 1'b0, 17'h02201);
    popWord("rnd_odd_r0", 1'b1, 17'h02200);
    applyStimulus(32'h33FF_FF00, 1'b0);
    applyStimulus(32'h44FF_FF00, 1'b1);
    popWord("sat_even_r1", 1'b0, 17'h033FF);
    popWord("sat_even_r0", 1'b1, 17'h033FF);
    popWord("sat_odd_r1", 1'b0, 17'h144FF);
    popWord("sat_odd_r0", 1'b1, 17'h144FF);
    idle(2);
    truncQ.delete();

    // Odd-length line, then pairing restarts
    applyStimulus(32'h0110_2000, 1'b0);
    applyStimulus(32'h0230_4000, 1'b0);
    applyStimulus(32'h5577_3300, 1'b1);
    popWord("odd_even", 1'b0, 17'h00130);
    popWord("odd_odd", 1'b0, 17'h00220);
    popWord("odd_solo", 1'b0, 17'h15533);
    applyStimulus(32'h6608_0400, 1'b0);
    applyStimulus(32'h770A_0600, 1'b1);
    popWord("odd_next_even", 1'b0, 17'h06605);
    popWord("odd_next_odd", 1'b0, 17'h17709);
    idle(2);
    truncQ.delete();

    // Backpressure
    dataout_ready = 1'b0;
    applyStimulus(32'h0A02_0400, 1'b0);
    applyStimulus(32'h0B04_0800, 1'b0);
    @(negedge clk);
    heldWord = dataout;
    checkOutput("bp_valid", 32'(dataout_valid), 32'd1);
    checkOutput("bp_word", 32'(heldWord), 32'h0A06);
    @(posedge clk);
    #1;
    stalls = 0;
    applyStimulus(32'h0C20_1000, 1'b0);
    checkOutput("bp_ready_sa", 32'(stalls), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_ready_sb", 32'(datain_ready), 32'd0);
      checkOutput("bp_stable", 32'(dataout), 32'h0A06);
      @(posedge clk);
      #1;
    end
    dataout_ready = 1'b1;
    applyStimulus(32'h0D40_3000, 1'b1);
    popWord("bp_w0", 1'b0, 17'h00A06);
    popWord("bp_w1", 1'b0, 17'h00B03);
    popWord("bp_w2", 1'b0, 17'h00C20);
    popWord("bp_w3", 1'b0, 17'h10D30);
    idle(4);
    checkOutput("bp_no_dup", 32'(outQ.size()), 32'd0);
    truncQ.delete();

    // Full-rate 16-pixel line
    outQ.delete();
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      yv[i]  = 8'(i + 1);
      crv[i] = 8'(5 * i);
      cbv[i] = 8'(3 * i + 7);
      applyStimulus({yv[i], crv[i], cbv[i], 8'h00}, i == 15);
      if (i == 0) firstInCyc = lastAcceptCyc;
    end
    idle(4);
    checkOutput("fr_stalls", 32'(stalls), 32'd0);
    checkOutput("fr_count", 32'(outQ.size()), 32'd16);
    checkOutput("fr_cycles", 32'(lastOutCyc - firstInCyc), 32'd17);
    for (int j = 0; j < 8; j++) begin
      popWord("fr_even", 1'b0, {1'b0, yv[2*j], avgRound(cbv[2*j], cbv[2*j+1])});
      popWord("fr_odd", 1'b0, {j == 7, yv[2*j+1], avgRound(crv[2*j], crv[2*j+1])});
    end
    truncQ.delete();

    // Reset mid-pair discards everything pending
    dataout_ready = 1'b0;
    outQ.delete();
    applyStimulus(32'h9999_9900, 1'b0);
    applyStimulus(32'h9898_9800, 1'b0);
    applyStimulus(32'h9797_9700, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mr_valid", 32'(dataout_valid), 32'd0);
    checkOutput("mr_ready", 32'(datain_ready), 32'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    dataout_ready = 1'b1;
    applyStimulus(32'h2102_0200, 1'b0);
    applyStimulus(32'h3104_0600, 1'b1);
    popWord("mr_even", 1'b0, 17'h02104);
    popWord("mr_odd", 1'b0, 17'h13103);
    idle(4);
    checkOutput("mr_no_stale", 32'(outQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ycrcb444_to_422_subsampler.md
Name: ycrcb444_to_422_subsampler

Overview:
- Sits directly downstream of the RGB-to-YCrCb converter. It consumes 4:4:4 pixel words {Y, Cr, Cb, pad} and emits 4:2:2 16-bit words {Y, C}.
- Pixels are processed in horizontal pairs. Chroma of each pair is averaged: the even word carries Cb_avg and the odd word carries Cr_avg.
- Valid/ready streaming on both sides, with a line-end flag. The block sustains one input pixel per cycle and one output word per cycle.

Parameters:
- DATAIN_WIDTH, 32, input word width. Fixed field layout: Y [31:24], Cr [23:16], Cb [15:8], [7:0] ignored.
- DATAOUT_WIDTH, 16, output word width. Layout: Y [15:8], C [7:0].
- CHROMA_ROUND, 1, averaging mode. 1 = (a+b+1)>>1 (round half up); 0 = (a+b)>>1 (truncate).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- datain  in  DATAIN_WIDTH  4:4:4 pixel {Y, Cr, Cb, pad}.
- datain_valid  in  1  input word valid.
- datain_last  in  1  marks the last pixel of a line; qualified by the transfer.
- datain_ready  out  1  block can accept datain this cycle.
- dataout  out  DATAOUT_WIDTH  4:2:2 word {Y, C}.
- dataout_valid  out  1  output word valid.
- dataout_last  out  1  last output word of a line.
- dataout_ready  in  1  downstream accepts dataout.

Behaviour:
- Transfers: an input transfer occurs when datain_valid && datain_ready. An output transfer occurs when dataout_valid && dataout_ready.
- Reset values: dataout = 0, dataout_valid = 0, dataout_last = 0, hold register empty, state = S_A. datain_ready is 0 while rst is high.
- Storage:
  - pixel-A register: Ya, Cra, Cba, a_last.
  - output register: dataout, dataout_valid, dataout_last.
  - hold register: one pending word, plus hold_valid and hold_last.
- out_free = !dataout_valid || dataout_ready.
- State S_A (expects the first pixel of a pair):
  - datain_ready = 1.
  - On transfer, capture the pixel into register A and produce no output.
  - datain_last = 0: go to S_B. datain_last = 1: go to S_SOLO.
- State S_B (expects the second pixel):
  - datain_ready = !hold_valid && out_free.
  - On transfer: dataout <= {Ya, avg(Cba, Cb_in)}, dataout_valid <= 1, dataout_last <= 0.
  - In the same cycle: hold <= {Y_in, avg(Cra, Cr_in)}, hold_valid <= 1, hold_last <= datain_last. Go to S_A.
- State S_SOLO (odd-length line, unpaired last pixel):
  - datain_ready = 0.
  - When !hold_valid && out_free: dataout <= {Ya, Cba}, dataout_valid <= 1, dataout_last <= 1. Cra is discarded. Go to S_A.
- Hold drain: in any state, when hold_valid && out_free and no S_B/S_SOLO load occurs that cycle:
  - dataout <= hold, dataout_last <= hold_last, hold_valid <= 0.
  - A load cannot coincide with hold_valid, because loads require !hold_valid.
- When out_free and there is nothing to load or drain: dataout_valid <= 0.
- Registered outputs (dataout, dataout_valid, dataout_last) are stable while dataout_valid && !dataout_ready.
- Latency: the even word is valid the cycle after the B-pixel transfer. The odd word is valid one cycle later if dataout_ready was high.
- Steady-state throughput with dataout_ready = 1 and datain_valid = 1 is 1 pixel in and 1 word out per cycle: A accepted while the hold drains; B accepted once the hold is empty.
- Averaging: 9-bit sum, result [8:1]. Never overflows; 0xFF + 0xFF gives 0xFF in both modes.
- Line framing: datain_last on a B pixel sets last on the odd word. Either way, the next accepted pixel is treated as an A pixel (pairing restarts per line).
- Reset mid-operation: a partially captured pair, the hold word and the output word are all discarded. No output is produced for them after reset.

Decomposition:
- Shared package ycrcb_stream_pkg:
  - field position constants: Y_MSB/LSB, CR_MSB/LSB, CB_MSB/LSB, OUT_Y and OUT_C ranges;
  - state encoding S_A, S_B, S_SOLO.
  - The upstream converter also uses this package.
- One combinational sub-module, chroma_avg. Parameter ROUND; inputs a[7:0], b[7:0]; output avg[7:0]. Instantiated twice, once for Cb and once for Cr.

Test Plan:
- Basic pair:
  - Stimulus: pixel A = {Y 0x10, Cr 0x80, Cb 0x40}, pixel B = {Y 0x20, Cr 0x82, Cb 0x43}, CHROMA_ROUND = 1, dataout_ready = 1.
  - Required: dataout 0x1042 one cycle after B, then 0x2081 the following cycle.
- Rounding:
  - Stimulus: Cb pair 0xFE/0xFF, in both modes.
  - Required: even word C = 0xFF with CHROMA_ROUND = 1, 0xFE with CHROMA_ROUND = 0. Cb pair 0xFF/0xFF gives 0xFF in both modes.
- Odd line:
  - Stimulus: three pixels, last on the third, which has Y 0x55, Cb 0x33.
  - Required: two paired words (dataout_last = 0 on both), then 0x5533 with dataout_last = 1. The next pixel is treated as an A pixel.
- Backpressure:
  - Stimulus: hold dataout_ready = 0 after a pair is accepted.
  - Required: dataout stays stable; datain_ready = 1 only in S_A, then 0 in S_B. After release, both words are delivered in order with no loss or duplication.
- Full rate:
  - Stimulus: 16-pixel line streamed with valid = 1 and ready = 1.
  - Required: 16 output words in 17 cycles, dataout_last only on word 16, datain_ready constantly 1.
- Reset mid-pair:
  - Stimulus: assert rst after pixel A is accepted.
  - Required: the next cycle shows dataout_valid = 0 and datain_ready = 0 while rst is high. After release, the next pixel pairs as an A pixel.
